// File: rtl/pipelined_8bit_sub_reader_pkg.sv
`default_nettype none
// =============================================================================
// Module      : pipelined_8bit_sub_reader_pkg
// Description : Shared widths, FSM state type and arithmetic helpers.
// Revision    : 1.0 - initial release
// =============================================================================
package pipelined_8bit_sub_reader_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int OP_W   = 7;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // A length field of zero stands for a full sweep of the cache.
    function automatic logic [CNT_W-1:0] scan_count(input logic [ADDR_W-1:0] len);
        return (len == '0) ? CNT_W'(DEPTH) : {1'b0, len};
    endfunction

    function automatic logic [DATA_W:0] sub9(input logic [DATA_W-1:0] sum,
                                             input logic [OP_W-1:0]   b);
        return {1'b0, sum} - {{(DATA_W + 1 - OP_W){1'b0}}, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_8bit_sub_reader_cache.sv
`default_nettype none
// =============================================================================
// Module      : sum_cache_ram
// Description : 64x8 cache, one synchronous write port, one read-first port.
// Revision    : 1.0 - initial release
// =============================================================================
module sum_cache_ram
    import pipelined_8bit_sub_reader_pkg::*;
(
    input  logic              clk,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Non-blocking write and read on the same edge gives old data on a collision.
    always_ff @(posedge clk) begin
        if (wen) begin
            r_mem[waddr] <= wdata;
        end
        rdata <= r_mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_8bit_sub_reader.sv
`default_nettype none
// =============================================================================
// Module      : pipelined_8bit_sub_reader
// Description : Scans a range of the sum cache, returning (sum - b) mod 256.
// Revision    : 1.0 - initial release
// =============================================================================
module pipelined_8bit_sub_reader
    import pipelined_8bit_sub_reader_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic wen,
    input  logic waddr_0_, waddr_1_, waddr_2_, waddr_3_, waddr_4_, waddr_5_,
    input  logic d_0_, d_1_, d_2_, d_3_, d_4_, d_5_, d_6_, d_7_,
    input  logic start,
    input  logic base_0_, base_1_, base_2_, base_3_, base_4_, base_5_,
    input  logic len_0_, len_1_, len_2_, len_3_, len_4_, len_5_,
    input  logic b_0_, b_1_, b_2_, b_3_, b_4_, b_5_, b_6_,
    output logic diff_0_, diff_1_, diff_2_, diff_3_,
    output logic diff_4_, diff_5_, diff_6_, diff_7_,
    output logic valid,
    output logic borrow,
    output logic busy,
    output logic done
);

    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_d;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_len;
    logic [OP_W-1:0]   w_b;

    assign w_waddr = {waddr_5_, waddr_4_, waddr_3_, waddr_2_, waddr_1_, waddr_0_};
    assign w_d     = {d_7_, d_6_, d_5_, d_4_, d_3_, d_2_, d_1_, d_0_};
    assign w_base  = {base_5_, base_4_, base_3_, base_2_, base_1_, base_0_};
    assign w_len   = {len_5_, len_4_, len_3_, len_2_, len_1_, len_0_};
    assign w_b     = {b_6_, b_5_, b_4_, b_3_, b_2_, b_1_, b_0_};

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_remaining;
    logic              w_issue;
    logic              w_busy;
    logic              w_last_issue;
    logic              w_retire_last;

    logic              r_s0_valid;
    logic              r_s0_last;
    logic [ADDR_W-1:0] r_s0_addr;
    logic [OP_W-1:0]   r_s0_b;

    logic              r_s1_valid;
    logic              r_s1_last;
    logic [OP_W-1:0]   r_s1_b;
    logic [DATA_W-1:0] w_s1_sum;

    logic [DATA_W-1:0] r_diff;
    logic              r_borrow;
    logic              r_valid;
    logic              r_done;

    assign w_last_issue  = w_issue && (r_remaining == CNT_W'(1));
    assign w_retire_last = r_s1_valid && r_s1_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start)         w_next_state = ST_SCAN;
            ST_SCAN:  if (w_last_issue)  w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_retire_last) w_next_state = ST_IDLE;
            default:                     w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue = (r_state == ST_SCAN);
        w_busy  = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_remaining <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_ptr       <= w_base;
            r_remaining <= scan_count(w_len);
        end else if (w_issue) begin
            r_ptr       <= r_ptr + ADDR_W'(1);
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_valid <= 1'b0;
            r_s0_last  <= 1'b0;
            r_s0_addr  <= '0;
            r_s0_b     <= '0;
        end else begin
            r_s0_valid <= w_issue;
            r_s0_last  <= w_last_issue;
            if (w_issue) begin
                r_s0_addr <= r_ptr;
                r_s0_b    <= w_b;
            end
        end
    end

    // Stage-1 sum comes straight out of the cache's registered read port.
    sum_cache_ram u_cache (
        .clk   (clk),
        .wen   (wen),
        .waddr (w_waddr),
        .wdata (w_d),
        .raddr (r_s0_addr),
        .rdata (w_s1_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_b     <= '0;
        end else begin
            r_s1_valid <= r_s0_valid;
            r_s1_last  <= r_s0_last;
            r_s1_b     <= r_s0_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_valid <= r_s1_valid;
            r_done  <= w_retire_last;
            if (r_s1_valid) begin
                {r_borrow, r_diff} <= sub9(w_s1_sum, r_s1_b);
            end
        end
    end

    assign {diff_7_, diff_6_, diff_5_, diff_4_,
            diff_3_, diff_2_, diff_1_, diff_0_} = r_diff;
    assign valid  = r_valid;
    assign borrow = r_borrow;
    assign busy   = w_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_8bit_sub_reader.sv
`default_nettype none
// =============================================================================
// Module      : tb_pipelined_8bit_sub_reader
// Description : Directed bench with a timeline model of the scan pipeline.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_pipelined_8bit_sub_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wen = 1'b0;
    logic [5:0] waddr = '0;
    logic [7:0] wd = '0;
    logic       start = 1'b0;
    logic [5:0] base = '0;
    logic [5:0] len = '0;
    logic [6:0] b_in = '0;
    logic [7:0] diff;
    logic       valid, borrow, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_done   = 0;

    always #5 clk = ~clk;

    pipelined_8bit_sub_reader dut (
        .clk(clk), .rst_n(rst_n), .wen(wen),
        .waddr_0_(waddr[0]), .waddr_1_(waddr[1]), .waddr_2_(waddr[2]),
        .waddr_3_(waddr[3]), .waddr_4_(waddr[4]), .waddr_5_(waddr[5]),
        .d_0_(wd[0]), .d_1_(wd[1]), .d_2_(wd[2]), .d_3_(wd[3]),
        .d_4_(wd[4]), .d_5_(wd[5]), .d_6_(wd[6]), .d_7_(wd[7]),
        .start(start),
        .base_0_(base[0]), .base_1_(base[1]), .base_2_(base[2]),
        .base_3_(base[3]), .base_4_(base[4]), .base_5_(base[5]),
        .len_0_(len[0]), .len_1_(len[1]), .len_2_(len[2]),
        .len_3_(len[3]), .len_4_(len[4]), .len_5_(len[5]),
        .b_0_(b_in[0]), .b_1_(b_in[1]), .b_2_(b_in[2]), .b_3_(b_in[3]),
        .b_4_(b_in[4]), .b_5_(b_in[5]), .b_6_(b_in[6]),
        .diff_0_(diff[0]), .diff_1_(diff[1]), .diff_2_(diff[2]), .diff_3_(diff[3]),
        .diff_4_(diff[4]), .diff_5_(diff[5]), .diff_6_(diff[6]), .diff_7_(diff[7]),
        .valid(valid), .borrow(borrow), .busy(busy), .done(done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each issued read is stamped with the edge it reads the cache and
    // the edge its result appears; the cache image is read before that edge's write.
    typedef struct {
        int rd_t;
        int out_t;
        int addr;
        int b;
        bit last;
        int val;
    } ent_t;

    ent_t q[$];
    int   mem [64];
    int   t = 0;
    bit   m_busy = 0;
    int   m_left = 0;
    int   m_ptr = 0;
    bit   exp_valid = 0, exp_done = 0, exp_borrow = 0;
    int   exp_diff = 0;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            m_busy = 0; m_left = 0; m_ptr = 0;
            exp_valid = 0; exp_done = 0; exp_borrow = 0; exp_diff = 0;
        end else begin
            bit busy_before;
            t++;
            busy_before = m_busy;
            exp_valid = 0;
            exp_done  = 0;
            foreach (q[i]) if (q[i].rd_t == t) q[i].val = mem[q[i].addr];
            if (q.size() > 0 && q[0].out_t == t) begin
                ent_t e;
                e = q.pop_front();
                exp_valid  = 1;
                exp_diff   = (e.val - e.b) & 255;
                exp_borrow = (e.val < e.b);
                exp_done   = e.last;
                if (e.last) m_busy = 0;
            end
            if (wen) mem[waddr] = int'(wd);
            if (m_left > 0) begin
                ent_t n;
                n.rd_t = t + 1; n.out_t = t + 2; n.addr = m_ptr;
                n.b = int'(b_in); n.last = (m_left == 1); n.val = 0;
                q.push_back(n);
                m_ptr  = (m_ptr + 1) % 64;
                m_left = m_left - 1;
            end
            if (!busy_before && start) begin
                m_busy = 1;
                m_ptr  = int'(base);
                m_left = (len == 0) ? 64 : int'(len);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_valid",  int'(valid),  int'(exp_valid));
            chk("cmp_diff",   int'(diff),   exp_diff);
            chk("cmp_borrow", int'(borrow), int'(exp_borrow));
            chk("cmp_done",   int'(done),   int'(exp_done));
            chk("cmp_busy",   int'(busy),   int'(m_busy));
            if (valid) n_valid++;
            if (done)  n_done++;
        end
    end

    // Callers are positioned at a negedge; each task returns at a later negedge.
    task automatic do_write(input int a, input int d);
        wen = 1'b1; waddr = 6'(a); wd = 8'(d);
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic do_start(input int ba, input int ln, input int bv);
        start = 1'b1; base = 6'(ba); len = 6'(ln); b_in = 7'(bv);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_reached", int'(busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int v0, d0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", int'(valid), 0);
        chk("rst_diff",  int'(diff),  0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // single entry, no borrow
        do_write(5, 8'h80);
        do_start(5, 1, 7'h10);
        chk("t1_busy", int'(busy), 1);
        @(negedge clk); chk("t1_valid_e1", int'(valid), 0);
        @(negedge clk); chk("t1_valid_e2", int'(valid), 0);
        @(negedge clk);
        chk("t1_valid", int'(valid), 1);
        chk("t1_diff", int'(diff), 8'h70);
        chk("t1_borrow", int'(borrow), 0);
        chk("t1_done", int'(done), 1);

        // address wrap 62 -> 1
        do_write(62, 3); do_write(63, 4); do_write(0, 5); do_write(1, 6);
        do_start(62, 4, 1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_valid", int'(valid), 1);
            chk("t2_diff", int'(diff), k + 2);
            chk("t2_done", int'(done), (k == 3) ? 1 : 0);
        end

        // borrow
        do_write(9, 8'h02);
        do_start(9, 1, 7'h05);
        repeat (3) @(negedge clk);
        chk("t3_diff", int'(diff), 8'hFD);
        chk("t3_borrow", int'(borrow), 1);

        // read-first collision, then rescan in the done cycle
        do_write(7, 8'h11);
        do_start(7, 1, 0);
        @(negedge clk);
        wen = 1'b1; waddr = 6'd7; wd = 8'h55;
        @(negedge clk);
        wen = 1'b0;
        @(negedge clk);
        chk("t4_old_diff", int'(diff), 8'h11);
        chk("t4_done", int'(done), 1);
        do_start(7, 1, 0);
        chk("t4_busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        chk("t4_new_diff", int'(diff), 8'h55);
        chk("t4_new_valid", int'(valid), 1);

        // full 64-entry sweep with an ignored mid-scan start
        for (int i = 0; i < 64; i++) do_write(i, i);
        v0 = n_valid; d0 = n_done;
        do_start(0, 0, 3);
        repeat (10) @(negedge clk);
        do_start(40, 2, 3);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("t5_valid_count", n_valid - v0, 64);
        chk("t5_done_count", n_done - d0, 1);

        // reset mid-scan
        do_start(20, 10, 1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(valid), 0);
        chk("t6_rst_diff", int'(diff), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_done", int'(done), 0);
        chk("t6_rst_borrow", int'(borrow), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        v0 = n_valid; d0 = n_done;
        repeat (20) @(negedge clk);
        chk("t6_no_valid", n_valid - v0, 0);
        chk("t6_no_done", n_done - d0, 0);
        do_start(20, 10, 1);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("t6_rescan_count", n_valid - v0, 10);
        chk("t6_rescan_done", n_done - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_8bit_sub_reader.md
PIPELINED_8BIT_SUB_READER -- requirements
Module: pipelined_8bit_sub_reader

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-003 SHALL have ports wen  input  1  and waddr_0_..waddr_5_  input  1 each  cache write enable and address.
REQ-004 SHALL have ports d_0_..d_7_  input  1 each  8-bit sum word written to the cache.
REQ-005 SHALL have port start  input  1  one-cycle scan request.
REQ-006 SHALL have ports base_0_..base_5_  input  1 each  first scan address.
REQ-007 SHALL have ports len_0_..len_5_  input  1 each  scan length; value 0 means 64 entries.
REQ-008 SHALL have ports b_0_..b_6_  input  1 each  7-bit subtrahend, sampled per issued read.
REQ-009 SHALL have ports diff_0_..diff_7_  output  1 each  (cached sum - b) mod 256.
REQ-010 SHALL have ports valid, borrow, busy, done  output  1 each  result valid, sum<b, scan active, last-result pulse.

Function
REQ-011 SHALL hold a 64x8 cache; when wen=1 at an edge, cache[waddr] <= d.
REQ-012 SHALL implement FSM IDLE -> SCAN -> DRAIN -> IDLE.
REQ-013 In IDLE, start=1 at an edge SHALL load ptr=base, remaining=len (0 -> 64, 7-bit counter), enter SCAN.
REQ-014 start while not IDLE SHALL be ignored, with no effect on the running scan.
REQ-015 Each SCAN cycle SHALL issue one read: stage0 captures ptr and b; ptr increments mod 64 (63 wraps to 0); remaining decrements.
REQ-016 Issue at remaining=1 SHALL be the last; FSM enters DRAIN, then returns to IDLE on the edge the last result registers.
REQ-017 Stage1 SHALL capture cache[stage0 addr] and stage0 b; stage2 (outputs) SHALL capture the 9-bit difference {0,sum} - {00,b}.
REQ-018 diff SHALL equal the low 8 bits of the difference; borrow SHALL equal bit 8 (1 iff sum < b).
REQ-019 Latency: start sampled at edge E0 -> first issue at E1 -> first valid=1 after E3; one result per cycle thereafter, no gaps.
REQ-020 valid SHALL be 1 exactly one cycle per issued read; diff/borrow SHALL hold their last value when valid=0.
REQ-021 done SHALL be 1 only in the cycle carrying the last result of a scan, coincident with valid.
REQ-022 busy SHALL be 1 from the edge after start is accepted until the edge on which done is registered; the next start is accepted in the cycle where done=1 is visible.
REQ-023 Simultaneous write and stage1 read of the same address SHALL return the old data (read-first).
REQ-024 Cache writes SHALL be permitted in every state and SHALL not stall the scan.

Reset
REQ-025 rst_n=0 SHALL immediately force FSM=IDLE, ptr=0, remaining=0, all pipeline valid bits 0, diff=0, borrow=0, valid=0, busy=0, done=0.
REQ-026 Reset mid-scan SHALL abort it; no valid or done SHALL appear for the aborted scan after release.
REQ-027 Cache contents SHALL not be reset; reads before the first write return unspecified data.

Structure
REQ-028 A shared package SHALL hold ADDR_W=6, DATA_W=8, OP_W=7, DEPTH=64, and the FSM state enum.
REQ-029 The cache SHALL be a sub-module sum_cache_ram (64x8, one synchronous write port, one synchronous read-first read port, no reset).
REQ-030 The top level SHALL contain only the FSM, the address/length counters, and the three-stage pipeline; total RTL 120-400 lines.

Verification
REQ-031 Write cache[5]=0x80, start base=5 len=1 b=0x10 -> valid after 3 cycles, diff=0x70, borrow=0, done=1 same cycle.
REQ-032 cache[62]=3, cache[63]=4, cache[0]=5, cache[1]=6, base=62 len=4 b=1 -> four consecutive valids, diff 2,3,4,5, done on the 4th only (address wrap).
REQ-033 cache[9]=0x02, b=0x05 -> diff=0xFD, borrow=1.
REQ-034 len=0, base=0, cache[i]=i -> exactly 64 valids, diff=i-b, done on the 64th; start pulsed mid-scan is ignored.
REQ-035 Write cache[7]=0x55 in the same cycle stage1 reads 7 (old 0x11), b=0 -> diff=0x11; a rescan -> diff=0x55.
REQ-036 rst_n pulsed low during a 10-entry scan -> outputs 0 immediately; no valid/done after release; a new scan then runs correctly.
